// File: rtl/glyph_text_render_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_pkg
//  Description : Shared constants for the on-screen text renderer: character
//                codes of the built-in 5x7 font and glyph/cell geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package glyph_pkg;

    typedef logic [4:0] glyph_code_t;

    localparam int GLYPH_W = 5;   // lit columns per glyph
    localparam int GLYPH_H = 7;   // lit rows per glyph
    localparam int CELL    = 8;   // cell pitch, includes one gap column/row

    localparam glyph_code_t CH_0     = 5'd0;
    localparam glyph_code_t CH_1     = 5'd1;
    localparam glyph_code_t CH_2     = 5'd2;
    localparam glyph_code_t CH_3     = 5'd3;
    localparam glyph_code_t CH_4     = 5'd4;
    localparam glyph_code_t CH_5     = 5'd5;
    localparam glyph_code_t CH_6     = 5'd6;
    localparam glyph_code_t CH_7     = 5'd7;
    localparam glyph_code_t CH_8     = 5'd8;
    localparam glyph_code_t CH_9     = 5'd9;
    localparam glyph_code_t CH_P     = 5'd10;
    localparam glyph_code_t CH_W     = 5'd11;
    localparam glyph_code_t CH_I     = 5'd12;
    localparam glyph_code_t CH_N     = 5'd13;
    localparam glyph_code_t CH_L     = 5'd14;
    localparam glyph_code_t CH_O     = 5'd15;
    localparam glyph_code_t CH_S     = 5'd16;
    localparam glyph_code_t CH_E     = 5'd17;
    localparam glyph_code_t CH_BLANK = 5'd31;

endpackage
`default_nettype wire

// File: rtl/glyph_text_render_if.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_text_render_if
//  Description : Pixel/text bus between the VGA timing/game logic (master)
//                and the text renderer (slave).
//                frame_tick, blink_en : per-frame strobe and blink enable
//                text_in              : packed codes, char 0 in the LSBs
//                start_x, start_y     : top-left corner of the string
//                x, y                 : current pixel position
//                display              : registered lit bit (2 clk latency)
//  Revision    : 1.0 - initial release
// ============================================================================
interface glyph_text_render_if #(
    parameter int NUM_CHARS = 4,
    parameter int CODE_W    = 5
);
    logic                          frame_tick;
    logic                          blink_en;
    logic [NUM_CHARS*CODE_W-1:0]   text_in;
    logic [9:0]                    start_x;
    logic [9:0]                    start_y;
    logic [9:0]                    x;
    logic [9:0]                    y;
    logic                          display;

    modport master (
        output frame_tick, blink_en, text_in, start_x, start_y, x, y,
        input  display
    );

    modport slave (
        input  frame_tick, blink_en, text_in, start_x, start_y, x, y,
        output display
    );
endinterface
`default_nettype wire

// File: rtl/glyph_font_rom.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_font_rom
//  Description : Combinational 5x7 font. Returns the five pixels of one glyph
//                row, MSB = leftmost column. Row 7 and unused codes are blank.
//                code_i : character code
//                row_i  : glyph row 0..7
//                bits_o : row pixels
//  Revision    : 1.0 - initial release
// ============================================================================
module glyph_font_rom
    import glyph_pkg::*;
(
    input  glyph_code_t  code_i,
    input  logic [2:0]   row_i,
    output logic [4:0]   bits_o
);

    logic [0:GLYPH_H-1][GLYPH_W-1:0] glyph;

    always_comb begin
        glyph = '0;
        case (code_i)
            CH_0: glyph = {5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110};
            CH_1: glyph = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
            CH_2: glyph = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
            CH_3: glyph = {5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110};
            CH_4: glyph = {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010};
            CH_5: glyph = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110};
            CH_6: glyph = {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110};
            CH_7: glyph = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000};
            CH_8: glyph = {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110};
            CH_9: glyph = {5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100};
            CH_P: glyph = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10000, 5'b10000, 5'b10000};
            CH_W: glyph = {5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10101, 5'b10101, 5'b01010};
            CH_I: glyph = {5'b01110, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
            CH_N: glyph = {5'b10001, 5'b11001, 5'b10101, 5'b10011, 5'b10001, 5'b10001, 5'b10001};
            CH_L: glyph = {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111};
            CH_O: glyph = {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110};
            CH_S: glyph = {5'b01111, 5'b10000, 5'b10000, 5'b01110, 5'b00001, 5'b00001, 5'b11110};
            CH_E: glyph = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111};
            default: glyph = '0;
        endcase

        // Row 7 is the inter-line gap of the 8x8 cell.
        bits_o = (row_i < 3'(GLYPH_H)) ? glyph[row_i] : 5'b00000;
    end

endmodule
`default_nettype wire

// File: rtl/glyph_text_render.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_text_render
//  Description : Two-stage pipelined text overlay. Stage 1 hit-tests the
//                pixel against the string box and picks the character code;
//                stage 2 looks up the font bit and applies blink masking.
//                clk, reset : system clock, synchronous active-high reset
//                bus        : glyph_text_render_if slave (see interface)
//  Revision    : 1.0 - initial release
// ============================================================================
module glyph_text_render
    import glyph_pkg::*;
#(
    parameter int NUM_CHARS    = 4,
    parameter int SCALE_LOG2   = 2,
    parameter int CODE_W       = 5,
    parameter int BLINK_FRAMES = 30
)(
    input  logic                clk,
    input  logic                reset,
    glyph_text_render_if.slave  bus
);

    localparam int               CELL_PX    = CELL << SCALE_LOG2;
    localparam logic [10:0]      TEXT_W     = 11'(NUM_CHARS * CELL_PX);
    localparam logic [10:0]      TEXT_H     = 11'(CELL_PX);
    localparam int               BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    // Shadow text and blink state
    logic [CODE_W-1:0]   shadow_q [NUM_CHARS];
    logic [BLINK_W-1:0]  blink_cnt_q;
    logic                phase_q;

    // Stage 1
    logic [10:0]         dx_d, dy_d, col_d;
    logic                inside_d, inside_q;
    logic [CODE_W-1:0]   code_d, code_q;
    logic [2:0]          gcol_d, gcol_q;
    logic [2:0]          grow_d, grow_q;

    // Stage 2
    logic [4:0]          font_bits;
    logic                bit_d;
    logic                display_d, display_q;

    // ------------------------------------------------------------------
    // Stage 1: hit test at 11 bits so start_x + width never wraps past 1023.
    // The x >= start_x term guarantees dx is the true non-negative offset,
    // which lets the upper bound compare against the offset directly.
    // ------------------------------------------------------------------
    always_comb begin
        dx_d     = {1'b0, bus.x} - {1'b0, bus.start_x};
        dy_d     = {1'b0, bus.y} - {1'b0, bus.start_y};
        inside_d = (bus.x >= bus.start_x) && (dx_d < TEXT_W) &&
                   (bus.y >= bus.start_y) && (dy_d < TEXT_H);
        col_d    = dx_d >> SCALE_LOG2;
        gcol_d   = col_d[2:0];
        grow_d   = dy_d[SCALE_LOG2 +: 3];

        // Character select; indices outside the string read as blank.
        code_d = '1;
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (col_d[10:3] == 8'(i)) begin
                code_d = shadow_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: font lookup, gap column, blink mask
    // ------------------------------------------------------------------
    glyph_font_rom u_font (
        .code_i (code_q),
        .row_i  (grow_q),
        .bits_o (font_bits)
    );

    always_comb begin
        bit_d     = (gcol_q < 3'(GLYPH_W)) ? font_bits[3'(GLYPH_W - 1) - gcol_q] : 1'b0;
        display_d = inside_q & bit_d & ~(bus.blink_en & phase_q);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                shadow_q[i] <= '1;
            end
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            inside_q    <= 1'b0;
            code_q      <= '1;
            gcol_q      <= '0;
            grow_q      <= '0;
            display_q   <= 1'b0;
        end else begin
            // Text only changes at frame boundaries so a frame never tears.
            if (bus.frame_tick) begin
                for (int i = 0; i < NUM_CHARS; i++) begin
                    shadow_q[i] <= bus.text_in[i*CODE_W +: CODE_W];
                end
                // Free-running even while blink is disabled.
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_q <= '0;
                    phase_q     <= ~phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
            inside_q  <= inside_d;
            code_q    <= code_d;
            gcol_q    <= gcol_d;
            grow_q    <= grow_d;
            display_q <= display_d;
        end
    end

    assign bus.display = display_q;

endmodule
`default_nettype wire
